// File: rtl/cic_decimation_sequencer.sv
// Sequencing controller for a CIC decimator: counts qualified samples, issues the
// downsample strobe, phase-aligns it to a sync marker and blanks disturbed outputs.
module cic_decimation_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int OUT_WIDTH      = 24,
  parameter int COUNT_WIDTH    = 12,
  parameter int SETTLE_OUTPUTS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfgStrobe,
  input  logic [COUNT_WIDTH-1:0] cfgFactor,
  output logic                   cfgError,
  output logic [COUNT_WIDTH-1:0] activeFactor,
  input  logic                   syncMarker,
  input  logic [DATA_WIDTH-1:0]  inTDATA,
  input  logic                   inTVALID,
  output logic [DATA_WIDTH-1:0]  cicTDATA,
  output logic                   cicTVALID,
  output logic                   cicDownsample,
  input  logic [OUT_WIDTH-1:0]   cicMTDATA,
  input  logic                   cicMTVALID,
  output logic [OUT_WIDTH-1:0]   outTDATA,
  output logic                   outTVALID,
  output logic                   aligned,
  output logic                   settling
);

  localparam int DISCARD_W = $clog2(SETTLE_OUTPUTS + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [COUNT_WIDTH-1:0] active_factor_q, active_factor_d;
  logic [COUNT_WIDTH-1:0] pending_factor_q, pending_factor_d;
  logic                   pending_flag_q, pending_flag_d;
  logic [COUNT_WIDTH-1:0] counter_q, counter_d;
  logic [DISCARD_W-1:0]   discard_count_q, discard_count_d;
  logic                   cfg_error_q, cfg_error_d;
  logic                   aligned_q, aligned_d;
  logic                   settling_q, settling_d;
  logic [DATA_WIDTH-1:0]  cic_tdata_q, cic_tdata_d;
  logic                   cic_tvalid_q, cic_tvalid_d;
  logic                   cic_downsample_q, cic_downsample_d;
  logic [OUT_WIDTH-1:0]   out_tdata_q, out_tdata_d;
  logic                   out_tvalid_q, out_tvalid_d;

  logic                   cfg_write_ok;
  logic                   qualified;
  logic                   sync_hit;
  logic                   at_zero;
  logic                   strobe;
  logic                   apply_now;
  logic                   disturb;
  logic [COUNT_WIDTH-1:0] next_factor;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d          = state_q;
    active_factor_d  = active_factor_q;
    pending_factor_d = pending_factor_q;
    pending_flag_d   = pending_flag_q;
    counter_d        = counter_q;
    discard_count_d  = discard_count_q;
    aligned_d        = aligned_q;

    cfg_write_ok = cfgStrobe && (cfgFactor >= COUNT_WIDTH'(2));
    cfg_error_d  = cfgStrobe && (cfgFactor < COUNT_WIDTH'(2));

    qualified   = inTVALID && (state_q != IDLE);
    sync_hit    = qualified && syncMarker;
    at_zero     = (counter_q == '0);
    strobe      = (qualified && at_zero) || sync_hit;
    apply_now   = pending_flag_q && strobe;
    next_factor = apply_now ? pending_factor_q : active_factor_q;
    disturb     = apply_now || (sync_hit && !at_zero);

    if (state_q == IDLE) begin
      // An accepted write takes effect straight away when nothing is running yet.
      if (cfg_write_ok) begin
        active_factor_d = cfgFactor;
        counter_d       = cfgFactor - COUNT_WIDTH'(1);
        discard_count_d = DISCARD_W'(SETTLE_OUTPUTS);
        state_d         = SETTLE;
      end
    end else begin
      if (apply_now)    pending_flag_d = 1'b0;
      if (cfg_write_ok) begin
        pending_factor_d = cfgFactor;
        pending_flag_d   = 1'b1;
      end

      active_factor_d = next_factor;
      if (strobe)         counter_d = next_factor - COUNT_WIDTH'(1);
      else if (qualified) counter_d = counter_q - COUNT_WIDTH'(1);

      if (sync_hit) aligned_d = at_zero;

      // A fresh disturbance restarts the discard window even mid-settle.
      if (disturb) begin
        discard_count_d = DISCARD_W'(SETTLE_OUTPUTS);
        state_d         = SETTLE;
      end else if ((state_q == SETTLE) && cicMTVALID) begin
        discard_count_d = discard_count_q - DISCARD_W'(1);
        if (discard_count_q <= DISCARD_W'(1)) state_d = RUN;
      end
    end

    cic_tdata_d      = inTDATA;
    cic_tvalid_d     = inTVALID;
    cic_downsample_d = strobe;
    out_tdata_d      = cicMTDATA;
    out_tvalid_d     = cicMTVALID && (state_q != SETTLE);
    settling_d       = (state_d == SETTLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      active_factor_q  <= '0;
      pending_factor_q <= '0;
      pending_flag_q   <= 1'b0;
      counter_q        <= '0;
      discard_count_q  <= '0;
      cfg_error_q      <= 1'b0;
      aligned_q        <= 1'b0;
      settling_q       <= 1'b0;
      cic_tdata_q      <= '0;
      cic_tvalid_q     <= 1'b0;
      cic_downsample_q <= 1'b0;
      out_tdata_q      <= '0;
      out_tvalid_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      active_factor_q  <= active_factor_d;
      pending_factor_q <= pending_factor_d;
      pending_flag_q   <= pending_flag_d;
      counter_q        <= counter_d;
      discard_count_q  <= discard_count_d;
      cfg_error_q      <= cfg_error_d;
      aligned_q        <= aligned_d;
      settling_q       <= settling_d;
      cic_tdata_q      <= cic_tdata_d;
      cic_tvalid_q     <= cic_tvalid_d;
      cic_downsample_q <= cic_downsample_d;
      out_tdata_q      <= out_tdata_d;
      out_tvalid_q     <= out_tvalid_d;
    end
  end

  assign cfgError      = cfg_error_q;
  assign activeFactor  = active_factor_q;
  assign cicTDATA      = cic_tdata_q;
  assign cicTVALID     = cic_tvalid_q;
  assign cicDownsample = cic_downsample_q;
  assign outTDATA      = out_tdata_q;
  assign outTVALID     = out_tvalid_q;
  assign aligned       = aligned_q;
  assign settling      = settling_q;

endmodule

// File: tb/tb_cic_decimation_sequencer.sv
// Directed bench for cic_decimation_sequencer: hand-computed strobe positions,
// discard windows, sync alignment, config errors and mid-settle reset.
module tb_cic_decimation_sequencer;

  localparam int DW = 16;
  localparam int OW = 24;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfgStrobe;
  logic [CW-1:0] cfgFactor;
  logic          cfgError;
  logic [CW-1:0] activeFactor;
  logic          syncMarker;
  logic [DW-1:0] inTDATA;
  logic          inTVALID;
  logic [DW-1:0] cicTDATA;
  logic          cicTVALID;
  logic          cicDownsample;
  logic [OW-1:0] cicMTDATA;
  logic          cicMTVALID;
  logic [OW-1:0] outTDATA;
  logic          outTVALID;
  logic          aligned;
  logic          settling;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cic_decimation_sequencer #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .COUNT_WIDTH(CW), .SETTLE_OUTPUTS(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cfgStrobe(cfgStrobe), .cfgFactor(cfgFactor), .cfgError(cfgError),
    .activeFactor(activeFactor), .syncMarker(syncMarker),
    .inTDATA(inTDATA), .inTVALID(inTVALID),
    .cicTDATA(cicTDATA), .cicTVALID(cicTVALID), .cicDownsample(cicDownsample),
    .cicMTDATA(cicMTDATA), .cicMTVALID(cicMTVALID),
    .outTDATA(outTDATA), .outTVALID(outTVALID),
    .aligned(aligned), .settling(settling)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cfgStrobe = 1'b0; cfgFactor = '0; syncMarker = 1'b0;
    inTDATA = '0; inTVALID = 1'b0; cicMTDATA = '0; cicMTVALID = 1'b0;
    tick(); tick();
    check("rst_cictvalid", cicTVALID, 0);
    check("rst_downsample", cicDownsample, 0);
    check("rst_outtvalid", outTVALID, 0);
    check("rst_cfgerror", cfgError, 0);
    check("rst_aligned", aligned, 0);
    check("rst_settling", settling, 0);
    check("rst_factor", activeFactor, 0);
    reset = 1'b0;
    tick();
    check("idle_no_strobe", cicDownsample, 0);

    // Factor 4 from reset, input valid on every cycle.
    cfgStrobe = 1'b1; cfgFactor = 12'd4; inTVALID = 1'b1; inTDATA = 16'h0055;
    tick();
    cfgStrobe = 1'b0;
    check("f4_active", activeFactor, 4);
    check("f4_cfgerror", cfgError, 0);
    check("f4_settling", settling, 1);
    check("f4_apply_nostrobe", cicDownsample, 0);
    for (int i = 0; i < 12; i++) begin
      inTDATA = DW'(16'h0100 + i);
      tick();
      check("f4_tdata", cicTDATA, 32'h0100 + i);
      check("f4_tvalid", cicTVALID, 1);
      check("f4_strobe", cicDownsample, (i % 4 == 3) ? 1 : 0);
    end
    inTVALID = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cicMTVALID = 1'b1; cicMTDATA = OW'(24'h200 + j);
      tick();
      check("f4_outtdata", outTDATA, 32'h200 + j);
      check("f4_outtvalid", outTVALID, (j == 4) ? 1 : 0);
      check("f4_settling_drain", settling, (j < 3) ? 1 : 0);
    end
    cicMTVALID = 1'b0;
    tick();
    check("f4_outtvalid_idle", outTVALID, 0);

    // Illegal factors are rejected.
    cfgStrobe = 1'b1; cfgFactor = 12'd1;
    tick();
    check("err1_pulse", cfgError, 1);
    check("err1_factor", activeFactor, 4);
    cfgFactor = 12'd0;
    tick();
    check("err0_pulse", cfgError, 1);
    check("err0_factor", activeFactor, 4);
    cfgStrobe = 1'b0;
    tick();
    check("err_clear", cfgError, 0);

    // Switch to 5 at the next boundary; counter sits at 3 here.
    cfgStrobe = 1'b1; cfgFactor = 12'd5;
    tick();
    cfgStrobe = 1'b0;
    check("f5_pending", activeFactor, 4);
    inTVALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("f5_boundary_strobe", cicDownsample, (k == 3) ? 1 : 0);
    end
    check("f5_active", activeFactor, 5);
    check("f5_settling", settling, 1);
    inTVALID = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cicMTVALID = 1'b1;
      tick();
      check("f5_discard", outTVALID, 0);
    end
    cicMTVALID = 1'b0;
    check("f5_settled", settling, 0);

    // Sync two samples after the strobe: counter not at boundary.
    inTVALID = 1'b1;
    tick();
    check("sync_pre", cicDownsample, 0);
    syncMarker = 1'b1;
    tick();
    syncMarker = 1'b0; inTVALID = 1'b0;
    check("sync_strobe", cicDownsample, 1);
    check("sync_unaligned", aligned, 0);
    check("sync_settling", settling, 1);
    for (int j = 0; j < 5; j++) begin
      cicMTVALID = 1'b1;
      tick();
      check("sync_discard", outTVALID, (j == 4) ? 1 : 0);
      check("sync_settling_drain", settling, (j < 3) ? 1 : 0);
    end
    cicMTVALID = 1'b0;

    // Repeat sync exactly on the boundary (counter reloaded to 4).
    inTVALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("async_gap", cicDownsample, 0);
    end
    syncMarker = 1'b1;
    tick();
    syncMarker = 1'b0;
    check("async_strobe", cicDownsample, 1);
    check("async_aligned", aligned, 1);
    check("async_no_settle", settling, 0);

    // Factor 8: write while counter is 4, apply after 5 samples.
    inTVALID = 1'b0; cfgStrobe = 1'b1; cfgFactor = 12'd8;
    tick();
    cfgStrobe = 1'b0; inTVALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("f8_apply_strobe", cicDownsample, (k == 4) ? 1 : 0);
    end
    check("f8_active", activeFactor, 8);

    // Write 3 mid-period: spacing stays 8 until the boundary, then 3.
    for (int k = 0; k < 8; k++) begin
      cfgStrobe = (k == 3); cfgFactor = 12'd3;
      tick();
      check("f8to3_strobe", cicDownsample, (k == 7) ? 1 : 0);
      check("f8to3_factor", activeFactor, (k == 7) ? 3 : 8);
    end
    cfgStrobe = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("f3_strobe", cicDownsample, (k % 3 == 2) ? 1 : 0);
    end

    // Alternating valid with factor 3; a sync on an idle cycle is ignored.
    for (int c = 0; c < 12; c++) begin
      inTVALID = (c % 2 == 0);
      syncMarker = (c == 7);
      tick();
      check("alt_tvalid", cicTVALID, (c % 2 == 0) ? 1 : 0);
      check("alt_strobe", cicDownsample, (c == 4 || c == 10) ? 1 : 0);
    end
    syncMarker = 1'b0;
    check("alt_sync_ignored", aligned, 1);
    check("alt_still_settling", settling, 1);

    // Reset while settling, with a pending write that must be lost.
    cfgStrobe = 1'b1; cfgFactor = 12'd6; inTVALID = 1'b0;
    tick();
    cfgStrobe = 1'b0;
    reset = 1'b1; inTVALID = 1'b1; inTDATA = 16'hBEEF;
    cicMTVALID = 1'b1; cicMTDATA = 24'hABCDEF;
    tick();
    check("rst2_cictvalid", cicTVALID, 0);
    check("rst2_cictdata", cicTDATA, 0);
    check("rst2_outtvalid", outTVALID, 0);
    check("rst2_outtdata", outTDATA, 0);
    check("rst2_factor", activeFactor, 0);
    check("rst2_settling", settling, 0);
    check("rst2_aligned", aligned, 0);
    reset = 1'b0; syncMarker = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("post_rst_strobe", cicDownsample, 0);
      check("post_rst_factor", activeFactor, 0);
      check("post_rst_outtvalid", outTVALID, 1);
    end
    syncMarker = 1'b0; cicMTVALID = 1'b0;
    cfgStrobe = 1'b1; cfgFactor = 12'd2;
    tick();
    cfgStrobe = 1'b0;
    check("post_rst_write", activeFactor, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
